zeroheti_apb_mtimer: RTL and testbench



---
 rtl/zeroheti_apb_mtimer.sv | 185 ++++++++++++++++++
 tb/tb_zeroheti_apb_mtimer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroheti_apb_mtimer.sv
// RISC-V machine timer on APB: 64-bit mtime with prescaler, mtimecmp, level IRQ.
// One-wait-state slave; MTIME_LO reads latch the high word for atomic 64-bit reads.
module zeroheti_apb_mtimer #(
    parameter int unsigned AddrWidth  = 12,
    parameter int unsigned PrescWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 psel_i,
    input  logic                 penable_i,
    input  logic                 pwrite_i,
    input  logic [AddrWidth-1:0] paddr_i,
    input  logic [31:0]          pwdata_i,
    input  logic [3:0]           pstrb_i,
    output logic [31:0]          prdata_o,
    output logic                 pready_o,
    output logic                 pslverr_o,
    output logic                 irq_o
);

    typedef enum logic {IDLE, RESP} state_e;

    state_e                state_q, state_d;
    logic [63:0]           mtime_q, mtime_d;
    logic [63:0]           mtimecmp_q, mtimecmp_d;
    logic                  en_q, en_d;
    logic                  irq_en_q, irq_en_d;
    logic [PrescWidth-1:0] presc_q, presc_d;
    logic [PrescWidth-1:0] presc_cnt_q, presc_cnt_d;
    logic [31:0]           hi_shadow_q, hi_shadow_d;
    logic [31:0]           prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  irq_q, irq_d;

    logic        access;
    logic        tick;
    logic        pend;
    logic [2:0]  idx;
    logic [63:0] mtime_inc;
    logic [31:0] ctrl_rd;
    logic [31:0] ctrl_wr;
    logic [31:0] rdata;
    logic        unused_bits;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wdata,
        input logic [3:0]  strb
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = strb[i] ? wdata[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    assign access    = (state_q == IDLE) && psel_i && penable_i;
    assign idx       = paddr_i[4:2];
    assign tick      = en_q && (presc_cnt_q == presc_q);
    assign mtime_inc = mtime_q + 64'd1;
    assign pend      = (mtime_q >= mtimecmp_q);

    always_comb begin
        ctrl_rd                 = '0;
        ctrl_rd[0]              = en_q;
        ctrl_rd[1]              = irq_en_q;
        ctrl_rd[8 +: PrescWidth] = presc_q;
    end

    assign ctrl_wr     = merge(ctrl_rd, pwdata_i, pstrb_i);
    assign unused_bits = ^{paddr_i, ctrl_wr};

    always_comb begin
        state_d     = state_q;
        prdata_d    = prdata_q;
        pslverr_d   = 1'b0;
        hi_shadow_d = hi_shadow_q;
        mtime_d     = tick ? mtime_inc : mtime_q;
        mtimecmp_d  = mtimecmp_q;
        en_d        = en_q;
        irq_en_d    = irq_en_q;
        presc_d     = presc_q;
        presc_cnt_d = presc_cnt_q;
        irq_d       = pend & irq_en_q;
        rdata       = '0;

        if (en_q) begin
            presc_cnt_d = tick ? '0 : presc_cnt_q + PrescWidth'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = RESP;
                    // A write beats a same-cycle tick only on the word it targets;
                    // the other word still takes the incremented value.
                    case (idx)
                        3'd0: begin
                            rdata = mtime_q[31:0];
                            if (pwrite_i) begin
                                mtime_d[31:0] = merge(mtime_q[31:0], pwdata_i, pstrb_i);
                            end else begin
                                hi_shadow_d = mtime_q[63:32];
                            end
                        end
                        3'd1: begin
                            rdata = hi_shadow_q;
                            if (pwrite_i) begin
                                mtime_d[63:32] = merge(mtime_q[63:32], pwdata_i, pstrb_i);
                            end
                        end
                        3'd2: begin
                            rdata = mtimecmp_q[31:0];
                            if (pwrite_i) begin
                                mtimecmp_d[31:0] = merge(mtimecmp_q[31:0], pwdata_i, pstrb_i);
                            end
                        end
                        3'd3: begin
                            rdata = mtimecmp_q[63:32];
                            if (pwrite_i) begin
                                mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], pwdata_i, pstrb_i);
                            end
                        end
                        3'd4: begin
                            rdata = ctrl_rd;
                            if (pwrite_i) begin
                                en_d        = ctrl_wr[0];
                                irq_en_d    = ctrl_wr[1];
                                presc_d     = ctrl_wr[8 +: PrescWidth];
                                presc_cnt_d = '0;
                            end
                        end
                        3'd5: begin
                            rdata = {31'b0, pend};
                        end
                        default: begin
                            pslverr_d = 1'b1;
                        end
                    endcase
                    prdata_d = pwrite_i ? 32'b0 : rdata;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            en_q        <= 1'b0;
            irq_en_q    <= 1'b0;
            presc_q     <= '0;
            presc_cnt_q <= '0;
            hi_shadow_q <= '0;
            prdata_q    <= '0;
            pslverr_q   <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            en_q        <= en_d;
            irq_en_q    <= irq_en_d;
            presc_q     <= presc_d;
            presc_cnt_q <= presc_cnt_d;
            hi_shadow_q <= hi_shadow_d;
            prdata_q    <= prdata_d;
            pslverr_q   <= pslverr_d;
            irq_q       <= irq_d;
        end
    end

    assign prdata_o  = prdata_q;
    assign pready_o  = (state_q == RESP);
    assign pslverr_o = pslverr_q;
    assign irq_o     = irq_q;

endmodule

// File: tb/tb_zeroheti_apb_mtimer.sv
// Directed bench for zeroheti_apb_mtimer: APB register access, prescaler,
// atomic reads, compare interrupt, strobes, errors and reset mid-transfer.
module tb_zeroheti_apb_mtimer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        psel_i;
    logic        penable_i;
    logic        pwrite_i;
    logic [11:0] paddr_i;
    logic [31:0] pwdata_i;
    logic [3:0]  pstrb_i;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        irq_o;

    int n_assert = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    zeroheti_apb_mtimer #(
        .AddrWidth (12),
        .PrescWidth(8)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .psel_i   (psel_i),
        .penable_i(penable_i),
        .pwrite_i (pwrite_i),
        .paddr_i  (paddr_i),
        .pwdata_i (pwdata_i),
        .pstrb_i  (pstrb_i),
        .prdata_o (prdata_o),
        .pready_o (pready_o),
        .pslverr_o(pslverr_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic apb(input logic wr, input logic [11:0] a, input logic [31:0] wd,
                       input logic [3:0] st, output logic [31:0] rd, output logic err);
        @(posedge clk_i); #1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = wr;
        paddr_i   = a;
        pwdata_i  = wd;
        pstrb_i   = st;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        chk("pready_acc1", pready_o, 0);
        @(posedge clk_i); #1;
        chk("pready_acc2", pready_o, 1);
        rd  = prdata_o;
        err = pslverr_o;
        @(posedge clk_i); #1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        chk("pready_done", pready_o, 0);
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] wd, input logic [3:0] st,
                      input logic exp_err, input string tag);
        logic [31:0] d;
        logic        e;
        apb(1'b1, a, wd, st, d, e);
        chk({tag, "_err"}, e, exp_err);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] expv,
                      input logic exp_err, input string tag);
        logic [31:0] d;
        logic        e;
        exp_q.push_back(expv);
        apb(1'b0, a, 32'h0, 4'h0, d, e);
        chk(tag, d, exp_q.pop_front());
        chk({tag, "_err"}, e, exp_err);
    endtask

    task automatic rd_raw(input logic [11:0] a, output logic [31:0] d);
        logic e;
        apb(1'b0, a, 32'h0, 4'h0, d, e);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a0;
        logic [31:0] b0;

        rst_i     = 1'b1;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = '0;
        pwdata_i  = '0;
        pstrb_i   = '0;
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_prdata", prdata_o, 0);
        chk("rst_pready", pready_o, 0);
        chk("rst_pslverr", pslverr_o, 0);
        chk("rst_irq", irq_o, 0);
        rst_i = 1'b0;

        rd(12'h00, 32'h0, 1'b0, "rst_mtime_lo");
        rd(12'h04, 32'h0, 1'b0, "rst_mtime_hi");
        rd(12'h08, 32'hFFFF_FFFF, 1'b0, "rst_cmp_lo");
        rd(12'h0C, 32'hFFFF_FFFF, 1'b0, "rst_cmp_hi");
        rd(12'h10, 32'h0, 1'b0, "rst_ctrl");
        rd(12'h14, 32'h0, 1'b0, "rst_status");
        chk("rst_irq_after", irq_o, 0);

        // prescaler 3: one increment every 4 cycles
        wr(12'h10, 32'h0000_0301, 4'hF, 1'b0, "ctrl_presc3");
        repeat (40) @(posedge clk_i);
        rd_raw(12'h00, v);
        chk("presc3_window", (v >= 32'd9 && v <= 32'd11), 1);
        rd(12'h10, 32'h0000_0301, 1'b0, "ctrl_rb");

        wr(12'h10, 32'h0000_0001, 4'hF, 1'b0, "ctrl_presc0");
        rd_raw(12'h00, a0);
        repeat (12) @(posedge clk_i);
        rd_raw(12'h00, b0);
        chk("presc0_adv16", b0 - a0, 16);

        // atomic read straddling the low-to-high carry
        wr(12'h10, 32'h0, 4'hF, 1'b0, "ctrl_off1");
        wr(12'h04, 32'h0, 4'hF, 1'b0, "mtime_hi0");
        wr(12'h00, 32'hFFFF_FFFC, 4'hF, 1'b0, "mtime_lo_fc");
        wr(12'h10, 32'h1, 4'hF, 1'b0, "ctrl_on1");
        rd(12'h00, 32'hFFFF_FFFF, 1'b0, "carry_lo");
        rd(12'h04, 32'h0, 1'b0, "carry_hi_shadow");
        wr(12'h10, 32'h0, 4'hF, 1'b0, "ctrl_off2");
        rd_raw(12'h00, v);
        rd(12'h04, 32'h1, 1'b0, "carry_hi_after");

        // compare interrupt
        wr(12'h00, 32'h0, 4'hF, 1'b0, "irq_mtime_lo");
        wr(12'h04, 32'h0, 4'hF, 1'b0, "irq_mtime_hi");
        wr(12'h08, 32'd20, 4'hF, 1'b0, "irq_cmp_lo");
        wr(12'h0C, 32'h0, 4'hF, 1'b0, "irq_cmp_hi");
        rd(12'h14, 32'h0, 1'b0, "status_pre");
        wr(12'h10, 32'h3, 4'hF, 1'b0, "ctrl_irq");
        repeat (18) @(posedge clk_i);
        #1;
        chk("irq_at19", irq_o, 0);
        @(posedge clk_i); #1;
        chk("irq_at20", irq_o, 0);
        @(posedge clk_i); #1;
        chk("irq_rise", irq_o, 1);
        rd(12'h14, 32'h1, 1'b0, "status_pend");

        @(posedge clk_i); #1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b1;
        paddr_i   = 12'h0C;
        pwdata_i  = 32'h1;
        pstrb_i   = 4'hF;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        chk("irq_hold", irq_o, 1);
        chk("irq_wr_pready", pready_o, 1);
        @(posedge clk_i); #1;
        chk("irq_fall", irq_o, 0);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        rd(12'h14, 32'h0, 1'b0, "status_clr");
        rd(12'h0C, 32'h1, 1'b0, "cmp_hi_rb");

        // byte-strobed write while ticking
        wr(12'h10, 32'h0, 4'hF, 1'b0, "ctrl_off3");
        wr(12'h00, 32'h00AB_0000, 4'hF, 1'b0, "strb_base");
        wr(12'h10, 32'h1, 4'hF, 1'b0, "ctrl_on2");
        wr(12'h00, 32'h1234_5678, 4'b0011, 1'b0, "strb_wr");
        wr(12'h10, 32'h0, 4'hF, 1'b0, "ctrl_off4");
        rd(12'h00, 32'h00AB_567C, 1'b0, "strb_lo");
        rd(12'h04, 32'h0, 1'b0, "strb_hi");

        // unmapped offsets
        wr(12'h18, 32'hFFFF_FFFF, 4'hF, 1'b1, "err_wr18");
        rd(12'h18, 32'h0, 1'b1, "err_rd18");
        rd(12'h1C, 32'h0, 1'b1, "err_rd1c");
        rd(12'h10, 32'h0, 1'b0, "err_ctrl_kept");
        rd(12'h08, 32'd20, 1'b0, "err_cmp_kept");
        rd(12'h00, 32'h00AB_567C, 1'b0, "err_mtime_kept");

        // psel dropped during the response cycle
        @(posedge clk_i); #1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        paddr_i   = 12'h08;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        chk("drop_pready", pready_o, 1);
        chk("drop_prdata", prdata_o, 32'd20);
        psel_i    = 1'b0;
        penable_i = 1'b0;
        @(posedge clk_i); #1;
        chk("drop_idle", pready_o, 0);
        rd(12'h0C, 32'h1, 1'b0, "drop_next_rd");

        // reset in the access cycle discards the write
        @(posedge clk_i); #1;
        psel_i    = 1'b1;
        penable_i = 1'b0;
        pwrite_i  = 1'b1;
        paddr_i   = 12'h08;
        pwdata_i  = 32'h0000_DEAD;
        pstrb_i   = 4'hF;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        rst_i     = 1'b1;
        @(posedge clk_i); #1;
        chk("rstmid_pready", pready_o, 0);
        rst_i     = 1'b0;
        psel_i    = 1'b0;
        penable_i = 1'b0;
        pwrite_i  = 1'b0;
        rd(12'h08, 32'hFFFF_FFFF, 1'b0, "rstmid_write_lost");
        rd(12'h00, 32'h0, 1'b0, "rstmid_mtime");
        chk("rstmid_irq", irq_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
